// File: rtl/pwm_capture.sv
// PWM capture: synchronises an external PWM input and measures the period
// and high time of each complete cycle, in system clocks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | stopped, RDY high, waiting for START
// S_ARM     | waiting for the first synchronised rising edge
// S_MEAS_HI | input high: counting period and high time
// S_MEAS_LO | input low: counting period; the next rise completes a cycle
module pwm_capture #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm_in,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_duty,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_rdy,
    output logic             o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS_HI,
        S_MEAS_LO
    } state_t;

    localparam logic [WIDTH-1:0] C_MAX = '1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_s_d;
    logic [WIDTH-1:0] r_cnt_p;
    logic [WIDTH-1:0] r_cnt_d;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_duty;
    logic             r_valid;
    logic             r_ovf;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_p_nxt;
    logic [WIDTH-1:0] w_cnt_d_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] w_duty_nxt;
    logic             w_valid_nxt;
    logic             w_ovf_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_max;

    assign w_rise    = r_sync2 & ~r_s_d;
    assign w_fall    = ~r_sync2 & r_s_d;
    assign w_cnt_max = (r_cnt_p == C_MAX);

    // Two-flop synchroniser plus delayed copy for edge detection; free-running.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= i_pwm_in;
            r_sync2 <= r_sync1;
            r_s_d   <= r_sync2;
        end
    end

    // State, counters and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt_p  <= '0;
            r_cnt_d  <= '0;
            r_period <= '0;
            r_duty   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt_p  <= w_cnt_p_nxt;
            r_cnt_d  <= w_cnt_d_nxt;
            r_period <= w_period_nxt;
            r_duty   <= w_duty_nxt;
            r_valid  <= w_valid_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    // Next-state and measurement update; STOP beats everything, then the
    // completing rise, then counter saturation.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_p_nxt  = r_cnt_p;
        w_cnt_d_nxt  = r_cnt_d;
        w_period_nxt = r_period;
        w_duty_nxt   = r_duty;
        w_valid_nxt  = 1'b0;
        w_ovf_nxt    = r_ovf;
        if (i_stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_p_nxt = '0;
            w_cnt_d_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = S_ARM;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_state_nxt = S_MEAS_HI;
                        w_cnt_p_nxt = C_ONE;
                        w_cnt_d_nxt = C_ONE;
                    end
                end
                S_MEAS_HI: begin
                    if (w_cnt_max) begin
                        w_state_nxt = S_ARM;
                        w_ovf_nxt   = 1'b1;
                        w_cnt_p_nxt = '0;
                        w_cnt_d_nxt = '0;
                    end else if (w_fall) begin
                        w_state_nxt = S_MEAS_LO;
                        w_cnt_p_nxt = r_cnt_p + C_ONE;
                    end else begin
                        w_cnt_p_nxt = r_cnt_p + C_ONE;
                        w_cnt_d_nxt = r_cnt_d + C_ONE;
                    end
                end
                S_MEAS_LO: begin
                    if (w_rise) begin
                        w_state_nxt  = S_MEAS_HI;
                        w_period_nxt = r_cnt_p;
                        w_duty_nxt   = r_cnt_d;
                        w_valid_nxt  = 1'b1;
                        w_cnt_p_nxt  = C_ONE;
                        w_cnt_d_nxt  = C_ONE;
                    end else if (w_cnt_max) begin
                        w_state_nxt = S_ARM;
                        w_ovf_nxt   = 1'b1;
                        w_cnt_p_nxt = '0;
                        w_cnt_d_nxt = '0;
                    end else begin
                        w_cnt_p_nxt = r_cnt_p + C_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign o_period = r_period;
    assign o_duty   = r_duty;
    assign o_valid  = r_valid;
    assign o_ovf    = r_ovf;
    assign o_busy   = (r_state != S_IDLE);
    assign o_rdy    = (r_state == S_IDLE);

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM capture/measurement block: the receive-side counterpart of the team's PWM generator. It samples an external PWM waveform, then measures the period and high time (duty) of each complete cycle in clock cycles. Each result is reported with a one-cycle valid strobe. It sits between a PWM input pin and a register/CPU interface, using the same SET-style start / STOP / BUSY / RDY control handshake as the generator.

## Interface
- `WIDTH`, 16: width of the period/duty counters and result registers; minimum 4.

- `CLK` in 1: system clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `PWM_IN` in 1: asynchronous PWM input.
- `START` in 1: begin measuring; sampled only in IDLE.
- `STOP` in 1: abort measurement, return to IDLE.
- `PERIOD` out WIDTH: last measured period, in clocks.
- `DUTY` out WIDTH: last measured high time, in clocks.
- `VALID` out 1: one-cycle pulse when `PERIOD`/`DUTY` update.
- `BUSY` out 1: high in ARM, MEAS_HI and MEAS_LO.
- `RDY` out 1: high in IDLE.
- `OVF` out 1: sticky overflow flag; cleared by `RST` or an accepted `START`.

## Operation
- **Input synchroniser.** `PWM_IN` passes through a 2-flop synchroniser to give `s`. A further register holds `s_d`.
  - `rise = s & ~s_d`; `fall = ~s & s_d`.
  - The synchroniser and edge detector run in every state.
- **State machine.**
  - IDLE:
    - `START & ~STOP` → ARM, and `OVF` clears to 0.
    - Otherwise stay in IDLE.
  - ARM: wait for `rise`.
    - On `rise` → MEAS_HI, with `cnt_p` = 1 and `cnt_d` = 1.
  - MEAS_HI:
    - `fall` → MEAS_LO, `cnt_p`++.
    - Otherwise `cnt_p`++ and `cnt_d`++.
  - MEAS_LO:
    - `rise` → MEAS_HI. Load `PERIOD` = `cnt_p` and `DUTY` = `cnt_d`, pulse `VALID`, and reload `cnt_p` = 1, `cnt_d` = 1.
    - Otherwise `cnt_p`++.
  - For a synchronised waveform high for H cycles and low for L cycles: `PERIOD` = H+L and `DUTY` = H.
- **Overflow.** Applies in MEAS_HI or MEAS_LO when `cnt_p` = 2^WIDTH−1 and the cycle is not a `rise` cycle in MEAS_LO.
  - `OVF` is set to 1 and the state goes to ARM.
  - The partial measurement is discarded, and `PERIOD`/`DUTY` hold.
  - This covers 100% duty (stuck high) and periods too long for WIDTH.
- **0% duty (stuck low).** The block stays in ARM (or MEAS_LO until overflow). No `VALID` is produced.
- **STOP.**
  - From any state, `STOP` → IDLE on the next edge.
  - Counters clear; `PERIOD`, `DUTY` and `OVF` hold; no `VALID` is produced.
  - `STOP` has priority over `START` and over a simultaneous `rise` completion, so no `VALID` is produced in that cycle.
- **START outside IDLE.** Ignored.
- **RST.** Applies in any state, including mid-measurement; everything returns to reset values on the next edge.
- **Arithmetic.** All arithmetic is unsigned, WIDTH bits. Counters never wrap; overflow handling above prevents it.

## Timing
- **Reset values:**
  - state = IDLE, `PERIOD` = 0, `DUTY` = 0, `VALID` = 0, `OVF` = 0, `BUSY` = 0, `RDY` = 1.
  - Synchroniser and `s_d` = 0.
- **Input latency.** A `PWM_IN` transition sampled at edge n appears on `s` after edge n+1. The resulting `rise`/`fall` is seen in the following cycle.
- **START latency.** `START` high at edge k puts the block in ARM after edge k; `BUSY` = 1 and `RDY` = 0 from then on.
- **Result latency.** `PERIOD`, `DUTY` and `VALID` are registered and change on the edge that processes the terminating `rise`.
  - `VALID` is high for exactly one cycle.
  - Consecutive `VALID` pulses are exactly `PERIOD` cycles apart in steady state.
- **Result stability.** `PERIOD`/`DUTY` stay stable between `VALID` pulses.
- **Status outputs.** `BUSY`/`RDY` are decoded from the registered state, with no combinational path from inputs.

## Test plan
- **Reset:** assert `RST` for 2 cycles with `PWM_IN` toggling → `PERIOD` = 0, `DUTY` = 0, `VALID` = 0, `OVF` = 0, `RDY` = 1, `BUSY` = 0.
- **Steady PWM:** `START`, then `PWM_IN` high 3 / low 5 repeated (WIDTH = 16) → first `VALID` only after one full cycle, then `PERIOD` = 8 and `DUTY` = 3 on every `VALID`, pulses 8 cycles apart.
- **Duty change:** switch to high 6 / low 2 mid-run → the next complete cycle reports `PERIOD` = 8 and `DUTY` = 6. No glitch or partial result appears.
- **Overflow:** WIDTH = 4, `PWM_IN` stuck high after one `rise` → `OVF` = 1 and state ARM after `cnt_p` reaches 15; no `VALID`; `PERIOD`/`DUTY` unchanged. A later `START` from IDLE clears `OVF`.
- **Abort:** `STOP` in MEAS_LO in the same cycle as the terminating `rise` → IDLE, no `VALID`, previous `PERIOD`/`DUTY` held, `RDY` = 1.
- **Priority:** `START` and `STOP` together in IDLE → remain in IDLE, `BUSY` = 0. `START` while `BUSY` → no effect on state or counters.
